pp_acc_seq: RTL

Sequential partial-product accumulator that sits directly downstream of the AND-array partial-product generator in the 8-bit signed multiplier. It accepts one flattened DW×DW partial-product bus per transaction and sums the rows one per cycle with the proper shifts. It adds the Baugh-Wooley correction constants 2^DW and 2^(2DW-1) and returns the 2DW-bit two's-complement product over a valid/ready handshake. It is the area-minimal, multi-cycle alternative to the combinational compressor tree, and it serves as a golden reference for that tree.

---
 rtl/pp_acc_seq.sv | 84 ++++++++
 1 files changed

// File: rtl/pp_acc_seq.sv
// Sequential Baugh-Wooley partial-product accumulator: sums one DW-bit row per
// cycle into a 2*DW-bit accumulator and returns the signed product over valid/ready.
//
// state  | meaning
// S_IDLE | waiting for a partial-product bus, pp_rdy high
// S_ACC  | adding row k (shifted by k) into the accumulator, one row per cycle
// S_DONE | product held on prod with prod_vld high until prod_rdy
module pp_acc_seq #(
   parameter int DW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pp_vld,
   output logic               pp_rdy,
   input  logic [DW*DW-1:0]   pp,
   input  logic               flush,
   output logic               prod_vld,
   input  logic               prod_rdy,
   output logic [2*DW-1:0]    prod,
   output logic               busy
);

   localparam int KW = (DW > 1) ? $clog2(DW) : 1;
   // 2^(2DW-1) + 2^DW: the Baugh-Wooley correction terms, preloaded on accept
   localparam logic [2*DW-1:0] C_BW = {1'b1, {(DW-2){1'b0}}, 1'b1, {DW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DW*DW-1:0]   r_rows;
   logic [2*DW-1:0]    r_acc;
   logic [KW-1:0]      r_k;
   logic               w_accept;
   logic               w_last;
   logic [2*DW-1:0]    w_addend;

   // flush blocks the accept so nothing is latched in the flush cycle
   assign w_accept = (r_state == S_IDLE) && pp_vld && !flush;
   assign w_last   = (r_k == KW'(DW-1));
   assign w_addend = {{DW{1'b0}}, r_rows[DW*r_k +: DW]} << r_k;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_ACC;
         S_ACC:   if (w_last)   w_state_nxt = S_DONE;
         S_DONE:  if (prod_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // carries out of the top bit are dropped on purpose; the correction terms rely on it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rows <= '0;
         r_acc  <= '0;
         r_k    <= '0;
      end else if (w_accept) begin
         r_rows <= pp;
         r_acc  <= C_BW;
         r_k    <= '0;
      end else if ((r_state == S_ACC) && !flush) begin
         r_acc  <= r_acc + w_addend;
         r_k    <= r_k + KW'(1);
      end
   end

   assign pp_rdy   = (r_state == S_IDLE);
   assign busy     = (r_state == S_ACC);
   assign prod_vld = (r_state == S_DONE);
   assign prod     = prod_vld ? r_acc : '0;

endmodule
